// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
//   timer_state_t   : FSM state encoding (IDLE, RUN, PAUSE, EXPIRED)
//   TENTH_MAX       : largest tenths digit value (9)
//   SEC_MAX_DEFAULT : default largest loadable seconds value (59)
//   clamp()         : saturate a value to an upper bound
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int unsigned TENTH_MAX       = 9;
  localparam int unsigned SEC_MAX_DEFAULT = 59;

  function automatic logic [7:0] clamp(input logic [7:0] value, input logic [7:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing one tick every CLK_HZ/TICK_HZ clocks while enabled.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   run   : count enable; count is held while low
//   clear : synchronous clear to 0, overrides run
//   tick  : combinational, high on the last count of a period while run is high
module tick_prescaler #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q;

  assign tick = run && (count_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run) begin
      if (tick) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Seconds/tenths countdown timer with load, pause/resume and expiry flagging.
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   load         : load clamped preset (highest priority)
//   en           : run enable level (count down when high)
//   preset_sec   : seconds to load, clamped to MAX_SEC
//   preset_tenth : tenths to load, clamped to 9
//   sec          : seconds remaining
//   tenth_sec    : tenths remaining
//   running      : high in RUN
//   expired      : high in EXPIRED
//   done         : one-cycle pulse on entry to EXPIRED
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 10,
  parameter int unsigned MAX_SEC = SEC_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [5:0] preset_sec,
  input  logic [3:0] preset_tenth,
  output logic [5:0] sec,
  output logic [3:0] tenth_sec,
  output logic       running,
  output logic       expired,
  output logic       done
);

  timer_state_t state_q;
  logic [5:0]   sec_q;
  logic [3:0]   tenth_q;
  logic         done_q;

  logic [5:0]   sec_clamp;
  logic [3:0]   tenth_clamp;
  logic         load_zero;
  logic         last_step;
  logic         tick;

  assign sec_clamp   = 6'(clamp({2'b00, preset_sec}, 8'(MAX_SEC)));
  assign tenth_clamp = 4'(clamp({4'b0000, preset_tenth}, 8'(TENTH_MAX)));
  assign load_zero   = (sec_clamp == '0) && (tenth_clamp == '0);

  // The next tick lands on 0.0 (tenth 0 with sec 0 is guarded too, though
  // RUN is never entered at 0.0).
  assign last_step   = (sec_q == '0) && (tenth_q <= 4'd1);

  // Prescaler advances in every RUN cycle, including the one where en drops,
  // so a pause resumes exactly where the period left off.
  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == RUN),
    .clear (load),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sec_q   <= '0;
      tenth_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        sec_q   <= sec_clamp;
        tenth_q <= tenth_clamp;
        state_q <= load_zero ? IDLE : PAUSE;
      end else begin
        unique case (state_q)
          IDLE: begin
          end
          PAUSE: begin
            if (en) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            if (tick) begin
              if (tenth_q != '0) begin
                tenth_q <= tenth_q - 4'd1;
              end else if (sec_q != '0) begin
                sec_q   <= sec_q - 6'd1;
                tenth_q <= 4'(TENTH_MAX);
              end
            end
            if (tick && last_step) begin
              state_q <= EXPIRED;
              done_q  <= 1'b1;
            end else if (!en) begin
              state_q <= PAUSE;
            end
          end
          EXPIRED: begin
            sec_q   <= '0;
            tenth_q <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sec       = sec_q;
  assign tenth_sec = tenth_q;
  assign running   = (state_q == RUN);
  assign expired   = (state_q == EXPIRED);
  assign done      = done_q;

endmodule
